// File: rtl/decoder_rr_sched.sv
// Round-robin front end for a shared 7-bit-input decoder: grants one requester,
// holds its code on dec_in for DEC_LAT cycles, then returns the tagged result.
module decoder_rr_sched #(
   parameter  int N_REQ   = 4,
   parameter  int OUT_W   = 8,
   parameter  int DEC_LAT = 1,
   localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [7*N_REQ-1:0] req_code,
   output logic [N_REQ-1:0]   req_ready,
   output logic [6:0]         dec_in,
   input  logic [OUT_W-1:0]   dec_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [OUT_W-1:0]   rsp_data,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr, ptr_nxt, winner, idx;
   logic [3:0]      cnt;
   logic            found, grant;
   logic [6:0]      codes [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_code
      assign codes[i] = req_code[7*i +: 7];
   end

   // First valid requester at or above ptr, wrapping at N_REQ-1.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign ptr_nxt = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found)      state_nxt = WAIT;
         WAIT:    if (cnt == '0)  state_nxt = RESP;
         RESP:    if (rsp_ready)  state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // reset gates the grant so nothing is offered while the block is held in reset
   always_comb begin
      busy  = (state != IDLE);
      grant = (state == IDLE) && found && !reset;
      for (int i = 0; i < N_REQ; i++)
         req_ready[i] = grant && (winner == ID_W'(i));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         cnt       <= '0;
         dec_in    <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               dec_in <= codes[winner];
               rsp_id <= winner;
               cnt    <= 4'(DEC_LAT);
               ptr    <= ptr_nxt;
            end
            WAIT: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  rsp_data  <= dec_out;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
